tick_pwm_gen: RTL



---
 rtl/tick_pwm_gen_pkg.sv | 20 ++
 rtl/tick_pwm_gen_edge_sel.sv | 49 ++++
 rtl/tick_pwm_gen.sv | 110 +++++++++++
 3 files changed

// File: rtl/tick_pwm_gen_pkg.sv
// Shared definitions for the tick-driven PWM generator.
//   DEF_CNT_W  : default width of the divider count bus
//   DEF_PWM_W  : default width of PWM counter / duty / period values
//   DEF_PERIOD : default PWM period in ticks
//   state_t    : run-control FSM states
//   tap_idx_t  : divider tap index
package tick_pwm_gen_pkg;

  localparam int DEF_CNT_W  = 4;
  localparam int DEF_PWM_W  = 8;
  localparam int DEF_PERIOD = 256;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic [1:0] tap_idx_t;

endpackage

// File: rtl/tick_pwm_gen_edge_sel.sv
// tick_edge_sel: picks one divider tap and turns its rising edge into a
// single-cycle registered tick.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   count_in  : divider count bus
//   tap_sel   : tap index into count_in
//   en        : run enable (gates tick immediately)
//   run       : controller is in RUN; arm only builds up while running
//   tick      : one-cycle pulse per rising edge of the selected tap
module tick_edge_sel
  import tick_pwm_gen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] count_in,
  input  tap_idx_t         tap_sel,
  input  logic             en,
  input  logic             run,
  output logic             tick
);

  logic     tap_bit;
  logic     tap_q;
  logic     arm;
  logic     sel_chg;
  tap_idx_t sel_q;

  assign tap_bit = count_in[tap_sel];
  assign sel_chg = (tap_sel != sel_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      tap_q <= 1'b0;
      sel_q <= '0;
      arm   <= 1'b0;
      tick  <= 1'b0;
    end else begin
      tap_q <= tap_bit;
      sel_q <= tap_sel;
      arm   <= run & en & ~sel_chg;
      // In the switch cycle itself tap_q still holds the old tap, so the
      // compare is meaningless; sel_chg masks it until arm drops.
      tick  <= en & arm & ~sel_chg & tap_bit & ~tap_q;
    end
  end

endmodule

// File: rtl/tick_pwm_gen.sv
// tick_pwm_gen: PWM generator advanced by a tick derived from a divider tap.
// Duty updates go through a one-entry shadow register and are applied only
// at the period wrap, so every period is a clean, complete waveform.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   count_in     : divider count bus (bit k toggles every 2^k clk)
//   tap_sel      : tap used as tick source
//   en           : run enable; 0 holds the PWM counter and forces pwm_out low
//   duty_in      : requested duty in ticks high per period
//   duty_valid   : duty_in valid
//   duty_ready   : shadow free; transfer on valid & ready
//   tick         : one-cycle pulse per rising edge of the selected tap
//   pwm_out      : PWM waveform
//   period_done  : one-cycle pulse after the PWM counter wraps
//
// state | meaning
// IDLE  | en low: counter frozen, pwm_out low, no ticks
// RUN   | en high: counter advances on tick, pwm_out follows compare
module tick_pwm_gen
  import tick_pwm_gen_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int PWM_W  = DEF_PWM_W,
  parameter int PERIOD = DEF_PERIOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] count_in,
  input  logic [1:0]       tap_sel,
  input  logic             en,
  input  logic [PWM_W-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             tick,
  output logic             pwm_out,
  output logic             period_done
);

  localparam logic [PWM_W-1:0] LAST = PWM_W'(PERIOD - 1);

  state_t           state;
  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] duty_act;
  logic [PWM_W-1:0] shadow;
  logic             shadow_full;
  logic             wrap;
  logic             accept;

  assign duty_ready = ~shadow_full;
  assign accept     = duty_valid & ~shadow_full;
  assign wrap       = tick & (pwm_cnt == LAST);

  tick_edge_sel #(
    .CNT_W (CNT_W)
  ) u_edge_sel (
    .clk      (clk),
    .rst      (rst),
    .count_in (count_in),
    .tap_sel  (tap_sel),
    .en       (en),
    .run      (state == RUN),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pwm_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pwm_out <= 1'b0;
          if (en) state <= RUN;
        end
        RUN: begin
          if (!en) begin
            state   <= IDLE;
            pwm_out <= 1'b0;
          end else begin
            // Counter never exceeds PERIOD-1, so duty >= PERIOD is always high.
            pwm_out <= (pwm_cnt < duty_act);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt     <= '0;
      duty_act    <= '0;
      shadow      <= '0;
      shadow_full <= 1'b0;
      period_done <= 1'b0;
    end else begin
      period_done <= wrap;
      if (tick) pwm_cnt <= wrap ? '0 : pwm_cnt + 1'b1;
      if (wrap && shadow_full) duty_act <= shadow;
      // Accept wins over the wrap-time drain so a new value landing on the
      // wrap keeps the shadow occupied for the next period.
      if (accept) begin
        shadow      <= duty_in;
        shadow_full <= 1'b1;
      end else if (wrap) begin
        shadow_full <= 1'b0;
      end
    end
  end

endmodule
